// File: rtl/seq_scan_pkg.sv
// Shared types for the shared-detector scan arbiter: control states and
// "101" detector state codes with their transition function.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    REPORT = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GOT1  = 2'd1;
  localparam logic [1:0] S_GOT10 = 2'd2;

  // Overlapping "101" detector: a match on S_GOT10 --1--> S_GOT1 keeps the
  // trailing 1 as the start of the next pattern.
  function automatic logic [1:0] det_next(input logic [1:0] s, input logic b);
    logic [1:0] n;
    n = S_IDLE;
    case (s)
      S_IDLE:  n = b ? S_GOT1 : S_IDLE;
      S_GOT1:  n = b ? S_GOT1 : S_GOT10;
      S_GOT10: n = b ? S_GOT1 : S_IDLE;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_scan_arbiter_pattern_det_fsm.sv
// Bit-serial overlapping "101" detector; match is flagged combinationally on
// the transition so the consumer can count it in the same cycle.
//   state   | meaning
//   S_IDLE  | no useful prefix seen
//   S_GOT1  | last bit was 1
//   S_GOT10 | last two bits were 1,0
module pattern_det_fsm
  import seq_scan_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic       o_match,
  output logic [1:0] o_state
);

  logic [1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (i_clr)
      state_d = S_IDLE;
    else if (i_en)
      state_d = det_next(state_q, i_bit);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  assign o_match = i_en && !i_clr && (state_q == S_GOT10) && i_bit;
  assign o_state = state_q;

endmodule

// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter that time-multiplexes one serial "101" detector across
// N_REQ word requesters and reports the per-word match count.
//   state  | meaning
//   IDLE   | waiting for any request; winner chosen from ptr onward
//   LOAD   | grant pulse, capture winner word, reset count and detector
//   SHIFT  | W cycles feeding word MSB-first into the detector
//   REPORT | done pulse with id/count/hit, advance round-robin pointer
module seq_scan_arbiter
  import seq_scan_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = 8,
  localparam int CNT_W = $clog2(W),
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*W-1:0] i_data,
  output logic [N_REQ-1:0]   o_gnt,
  output logic               o_busy,
  output logic               o_done,
  output logic [ID_W-1:0]    o_done_id,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_hit
);

  ctrl_state_e      state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  winner_q, winner_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic             hit_q, hit_d;

  logic [W-1:0]     data_arr [N_REQ];
  logic [ID_W-1:0]  pick;
  logic             det_clr, det_en, det_match;
  logic [1:0]       det_state;

  always_comb begin
    for (int k = 0; k < N_REQ; k++)
      data_arr[k] = i_data[k*W +: W];
  end

  // First requester at or after ptr, wrapping around.
  always_comb begin
    int  idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!found && i_req[ID_W'(idx)]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  // A detector left in S_IDLE by the previous word needs no clear.
  assign det_clr = (state_q == LOAD) && (det_state != S_IDLE);
  assign det_en  = (state_q == SHIFT);

  pattern_det_fsm u_det (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (det_clr),
    .i_en    (det_en),
    .i_bit   (shreg_q[W-1]),
    .o_match (det_match),
    .o_state (det_state)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    count_d   = count_q;
    gnt_d     = '0;
    done_d    = 1'b0;
    done_id_d = '0;
    cnt_out_d = '0;
    hit_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          winner_d    = pick;
          gnt_d[pick] = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        shreg_d  = data_arr[winner_q];
        count_d  = '0;
        bitcnt_d = CNT_W'(W - 1);
        state_d  = SHIFT;
      end
      SHIFT: begin
        shreg_d  = {shreg_q[W-2:0], 1'b0};
        count_d  = count_q + CNT_W'(det_match);
        bitcnt_d = bitcnt_q - 1'b1;
        if (bitcnt_q == '0) begin
          state_d   = REPORT;
          done_d    = 1'b1;
          done_id_d = winner_q;
          cnt_out_d = count_d;
          hit_d     = (count_d != '0);
        end
      end
      REPORT: begin
        ptr_d   = (winner_q == ID_W'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      winner_q  <= '0;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      count_q   <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      cnt_out_q <= '0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      count_q   <= count_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      cnt_out_q <= cnt_out_d;
      hit_q     <= hit_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_done_id = done_id_q;
  assign o_count   = cnt_out_q;
  assign o_hit     = hit_q;

endmodule
